mips_cpu_muldiv_unit: RTL

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the MIPS CPU. It executes MULT, MULTU, DIV and DIVU with an iterative radix-2 shift-add / restoring-divide datapath, and executes MTHI and MTLO in a single cycle. It raises `busy` while an operation is in flight; the pipeline control stalls any HI/LO access (MFHI, MFLO, MTHI, MTLO, further mult/div) until `busy` falls.

---
 rtl/mips_cpu_muldiv_unit_if.sv | 21 ++
 rtl/mips_cpu_muldiv_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv_unit_if.sv
// HI/LO multiply/divide unit bus: request, operands and result/status.
interface mips_cpu_muldiv_unit_if;
  logic        start;
  logic [5:0]  fn;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, fn, data_1, data_2,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, fn, data_1, data_2,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative MIPS multiply/divide sequencer owning the HI/LO pair.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo written here in one cycle
// MUL   | shift-add, one multiplier bit per cycle, LSB first
// DIV   | restoring divide, one quotient bit per cycle, MSB first
// FIX   | apply result signs, write hi/lo, pulse done
module mips_cpu_muldiv_unit #(
  parameter int ITER = 32
) (
  input logic                   clk,
  input logic                   reset,
  mips_cpu_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] LAST     = 6'(ITER - 1);

  state_t      state;
  logic [5:0]  cnt;
  // MUL: {partial product high, remaining multiplier}; DIV: {remainder, dividend/quotient}
  logic [63:0] acc;
  logic [31:0] opb;
  logic        is_div;
  logic        neg_lo;
  logic        neg_hi;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        op_mul;
  logic        op_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand decode/magnitude and one-step datapath arithmetic
  always_comb begin
    op_mul    = (bus.fn == FN_MULT) || (bus.fn == FN_MULTU);
    op_div    = (bus.fn == FN_DIV)  || (bus.fn == FN_DIVU);
    a_neg     = ((bus.fn == FN_MULT) || (bus.fn == FN_DIV)) && bus.data_1[31];
    b_neg     = ((bus.fn == FN_MULT) || (bus.fn == FN_DIV)) && bus.data_2[31];
    a_mag     = a_neg ? (~bus.data_1 + 32'd1) : bus.data_1;
    b_mag     = b_neg ? (~bus.data_2 + 32'd1) : bus.data_2;
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opb : 32'd0)};
    div_shift = acc[63:31];
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    prod_fix  = neg_lo ? (~acc + 64'd1) : acc;
    q_fix     = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
    r_fix     = neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  // Sequencer FSM with registered busy/done and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (op_mul) begin
              acc    <= {32'd0, b_mag};
              opb    <= a_mag;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= 1'b0;
              is_div <= 1'b0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end else if (op_div) begin
              acc    <= {32'd0, a_mag};
              opb    <= b_mag;
              // divide by zero keeps the all-ones quotient unnegated
              neg_lo <= (a_neg ^ b_neg) && (bus.data_2 != 32'd0);
              neg_hi <= a_neg;
              is_div <= 1'b1;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= DIV;
            end else if (bus.fn == FN_MTHI) begin
              hi <= bus.data_1;
            end else if (bus.fn == FN_MTLO) begin
              lo <= bus.data_1;
            end
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= FIX;
        end
        DIV: begin
          if (!div_diff[33]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
          else               acc <= {div_shift[31:0], acc[30:0], 1'b0};
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;

endmodule
